// File: rtl/data_sram_resp.sv
// data_sram_resp: single-cycle-latency word RAM with an MMIO register window.
//
// Every access takes exactly one cycle and returns data on the next cycle.
// There is no stall signal, so a new access can be issued every cycle.
// Reads are read-first: a write returns the word's previous contents.
//
// Ports
//   clk    in   1   clock; all state changes on the rising edge
//   reset  in   1   synchronous, active-high reset
//   en     in   1   access request, one access per cycle
//   we     in   4   byte write enables; all zero means a read
//   addr   in  32   byte address; addr[1:0] are ignored
//   wdata  in  32   write data
//   rdata  out 32   registered read data
//   led    out 16   LED register
//   timer  out 32   free-running timer
//
// MMIO window (addr[31:16] == MMIO_BASE[31:16]), offset addr[15:0]
//   0x00 LED (16 bit, RW)   0x04 TIMER (RW)     0x08 SCRATCH (RW)
//   0x0C ID (RO)            0x10 RD_CNT (RO)    0x14 WR_CNT (RO)
//   Any other offset reads 0 and ignores writes.
module data_sram_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000,
  parameter logic [31:0] ID_VALUE   = 32'h4C41_3332
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [31:0] timer
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // RAM storage; deliberately not reset so it maps onto block RAM.
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_ram_q;

  logic [15:0] r_led;
  logic [31:0] r_timer;
  logic [31:0] r_scratch;
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_mmio_q;
  // Selects which read register drives rdata. It changes only on an
  // accepted access, so rdata holds its value while en is low.
  logic        r_src_mmio;

  logic                  w_is_mmio;
  logic                  w_acc;
  logic                  w_ram_acc;
  logic                  w_mmio_acc;
  logic                  w_wr;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [13:0]           w_reg;
  logic                  w_wr_led;
  logic                  w_wr_timer;
  logic                  w_wr_scratch;
  logic [31:0]           w_timer_merged;
  logic [31:0]           w_scratch_merged;
  logic [31:0]           w_mmio_rdata;

  // An access presented while reset is high is discarded entirely.
  assign w_is_mmio  = (addr[31:16] == MMIO_BASE[31:16]);
  assign w_acc      = en & ~reset;
  assign w_ram_acc  = w_acc & ~w_is_mmio;
  assign w_mmio_acc = w_acc & w_is_mmio;
  assign w_wr       = |we;
  assign w_idx      = addr[DEPTH_LOG2+1:2];
  assign w_reg      = addr[15:2];

  assign w_wr_led     = w_mmio_acc & w_wr & (w_reg == 14'h0);
  assign w_wr_timer   = w_mmio_acc & w_wr & (w_reg == 14'h1);
  assign w_wr_scratch = w_mmio_acc & w_wr & (w_reg == 14'h2);

  // Byte-lane merge for the full-width writable registers.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_timer_merged[8*gi +: 8]   = we[gi] ? wdata[8*gi +: 8] : r_timer[8*gi +: 8];
      assign w_scratch_merged[8*gi +: 8] = we[gi] ? wdata[8*gi +: 8] : r_scratch[8*gi +: 8];
    end
  endgenerate

  // RAM: the registered read samples the old word in the same edge as the
  // write, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (w_ram_acc) begin
      r_ram_q <= r_mem[w_idx];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // MMIO read mux over the current register values (pre-write contents).
  always_comb begin
    w_mmio_rdata = 32'h0;
    case (w_reg)
      14'h0:   w_mmio_rdata = {16'h0, r_led};
      14'h1:   w_mmio_rdata = r_timer;
      14'h2:   w_mmio_rdata = r_scratch;
      14'h3:   w_mmio_rdata = ID_VALUE;
      14'h4:   w_mmio_rdata = r_rd_cnt;
      14'h5:   w_mmio_rdata = r_wr_cnt;
      default: w_mmio_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led      <= 16'h0;
      r_timer    <= 32'h0;
      r_scratch  <= 32'h0;
      r_rd_cnt   <= 32'h0;
      r_wr_cnt   <= 32'h0;
      r_mmio_q   <= 32'h0;
      r_src_mmio <= 1'b1;
    end else begin
      if (w_wr_led) begin
        if (we[0]) r_led[7:0]  <= wdata[7:0];
        if (we[1]) r_led[15:8] <= wdata[15:8];
      end

      // A software write wins over the free-running increment.
      if (w_wr_timer) begin
        r_timer <= w_timer_merged;
      end else begin
        r_timer <= r_timer + 32'd1;
      end

      if (w_wr_scratch) begin
        r_scratch <= w_scratch_merged;
      end

      // Saturating access counters; MMIO traffic is not counted.
      if (w_ram_acc) begin
        if (w_wr) begin
          if (r_wr_cnt != 32'hFFFF_FFFF) r_wr_cnt <= r_wr_cnt + 32'd1;
        end else begin
          if (r_rd_cnt != 32'hFFFF_FFFF) r_rd_cnt <= r_rd_cnt + 32'd1;
        end
      end

      if (w_acc) begin
        r_src_mmio <= w_is_mmio;
      end
      if (w_mmio_acc) begin
        r_mmio_q <= w_mmio_rdata;
      end
    end
  end

  assign rdata = r_src_mmio ? r_mmio_q : r_ram_q;
  assign led   = r_led;
  assign timer = r_timer;

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

  localparam logic [31:0] BASE  = 32'hBFAF_0000;
  localparam logic [31:0] ID    = 32'h4C41_3332;
  localparam int          WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [31:0] timer;

  int errors = 0;
  int checks = 0;
  bit verbose = 1'b0;

  // Reference model state
  logic [31:0] m_mem [WORDS];
  logic [31:0] m_rdata;
  logic [15:0] m_led;
  logic [31:0] m_timer;
  logic [31:0] m_scratch;
  logic [31:0] m_rd;
  logic [31:0] m_wr;

  data_sram_resp dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .led   (led),
    .timer (timer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) if (w[i]) res[8*i +: 8] = d[8*i +: 8];
    return res;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Behavioural model of one clock edge, stated directly from the rules.
  task automatic model_step(input logic e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, input logic r);
    logic [31:0] next_timer;
    logic [31:0] tmp;
    int idx;
    if (r) begin
      m_rdata = 0; m_led = 0; m_timer = 0; m_scratch = 0; m_rd = 0; m_wr = 0;
      return;
    end
    next_timer = m_timer + 32'd1;
    if (e) begin
      if (a[31:16] != BASE[31:16]) begin
        idx = int'((a >> 2) % WORDS);
        m_rdata = m_mem[idx];
        if (w == 4'h0) m_rd = sat_inc(m_rd);
        else begin
          m_wr = sat_inc(m_wr);
          m_mem[idx] = merge(m_mem[idx], d, w);
        end
      end else begin
        case (a[15:0] & 16'hFFFC)
          16'h0000: begin
            m_rdata = {16'h0, m_led};
            tmp = merge({16'h0, m_led}, d, w);
            m_led = tmp[15:0];
          end
          16'h0004: begin
            m_rdata = m_timer;
            if (w != 4'h0) next_timer = merge(m_timer, d, w);
          end
          16'h0008: begin
            m_rdata = m_scratch;
            m_scratch = merge(m_scratch, d, w);
          end
          16'h000C: m_rdata = ID;
          16'h0010: m_rdata = m_rd;
          16'h0014: m_rdata = m_wr;
          default:  m_rdata = 32'h0;
        endcase
      end
    end
    m_timer = next_timer;
  endtask

  // One clock cycle: drive, clock, update model, compare outputs.
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input logic r);
    en = e; we = w; addr = a; wdata = d; reset = r;
    @(posedge clk);
    model_step(e, w, a, d, r);
    #1;
    if (!$isunknown(m_rdata)) chk("rdata", rdata, m_rdata);
    chk("led", {16'h0, led}, {16'h0, m_led});
    chk("timer", timer, m_timer);
    if (verbose)
      $display("cyc rst=%0b en=%0b we=%h addr=%h wdata=%h -> rdata=%h led=%h timer=%h",
               r, e, w, a, d, rdata, led, timer);
  endtask

  logic [31:0] saved;
  logic [31:0] ra;
  logic [3:0]  rw;

  initial begin
    en = 0; we = 0; addr = 0; wdata = 0; reset = 1;
    for (int i = 0; i < WORDS; i++) m_mem[i] = 'x;
    m_rdata = 0; m_led = 0; m_timer = 0; m_scratch = 0; m_rd = 0; m_wr = 0;

    // Reset with an access presented: it must be discarded.
    verbose = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 4'hF, 32'h0, 32'hDEAD_BEEF, 1);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_timer", timer, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    cyc(0, 4'h0, 32'h0, 32'h0, 0);
    chk("timer_after_reset", timer, 32'h1);

    // Fill the whole RAM so every later read has a known expectation.
    verbose = 1'b0;
    for (int i = 0; i < WORDS; i++) cyc(1, 4'hF, 32'(i * 4), $urandom, 0);
    verbose = 1'b1;

    // Byte-lane write
    cyc(1, 4'hF, 32'h100, 32'h1122_3344, 0);
    cyc(1, 4'h8, 32'h100, 32'hAA55_6677, 0);
    cyc(1, 4'h0, 32'h100, 32'h0, 0);
    chk("byte_lane", rdata, 32'hAA22_3344);

    // Read-first and back-to-back
    cyc(1, 4'hF, 32'h200, 32'd5, 0);
    cyc(1, 4'hF, 32'h200, 32'd9, 0);
    chk("read_first", rdata, 32'd5);
    cyc(1, 4'h0, 32'h200, 32'h0, 0);
    chk("back_to_back", rdata, 32'd9);
    cyc(0, 4'h0, 32'h200, 32'h0, 0);
    chk("hold_en0", rdata, 32'd9);

    // Index wrap
    cyc(1, 4'hF, 32'h1000_0000, 32'h0000_CAFE, 0);
    cyc(1, 4'h0, 32'h0000_0000, 32'h0, 0);
    chk("wrap", rdata, 32'h0000_CAFE);

    // Timer write and wrap
    cyc(1, 4'hF, BASE + 32'h4, 32'hFFFF_FFFE, 0);
    chk("timer_wr", timer, 32'hFFFF_FFFE);
    cyc(0, 4'h0, 32'h0, 32'h0, 0);
    chk("timer_max", timer, 32'hFFFF_FFFF);
    cyc(0, 4'h0, 32'h0, 32'h0, 0);
    chk("timer_wrap", timer, 32'h0);

    // MMIO registers
    cyc(1, 4'hF, BASE + 32'h0, 32'h0001_ABCD, 0);
    chk("led_wr", {16'h0, led}, 32'h0000_ABCD);
    cyc(1, 4'h0, BASE + 32'h0, 32'h0, 0);
    chk("led_rd", rdata, 32'h0000_ABCD);
    cyc(1, 4'h0, BASE + 32'hC, 32'h0, 0);
    chk("id_rd", rdata, ID);
    cyc(1, 4'hF, BASE + 32'h8, 32'h1234_5678, 0);
    cyc(1, 4'hF, BASE + 32'h20, 32'hFFFF_FFFF, 0);
    chk("unmapped_wr_rdata", rdata, 32'h0);
    cyc(1, 4'h0, BASE + 32'h8, 32'h0, 0);
    chk("scratch_kept", rdata, 32'h1234_5678);
    cyc(1, 4'hF, BASE + 32'hC, 32'h0, 0);
    cyc(1, 4'h0, BASE + 32'hC, 32'h0, 0);
    chk("id_ro", rdata, ID);
    chk("led_kept", {16'h0, led}, 32'h0000_ABCD);

    // Counters, then reset during a write
    cyc(0, 4'h0, 32'h0, 32'h0, 1);
    cyc(1, 4'h0, 32'h10, 32'h0, 0);
    cyc(1, 4'h0, 32'h14, 32'h0, 0);
    cyc(1, 4'h0, 32'h18, 32'h0, 0);
    cyc(1, 4'hF, 32'h1C, 32'h0000_0111, 0);
    cyc(1, 4'h3, 32'h20, 32'h0000_0222, 0);
    cyc(1, 4'h0, BASE + 32'h10, 32'h0, 0);
    chk("rd_cnt", rdata, 32'd3);
    cyc(1, 4'h0, BASE + 32'h14, 32'h0, 0);
    chk("wr_cnt", rdata, 32'd2);
    saved = m_mem[32'h300 >> 2];
    cyc(1, 4'hF, 32'h300, ~saved, 1);
    chk("reset_wr_rdata", rdata, 32'h0);
    cyc(1, 4'h0, BASE + 32'h10, 32'h0, 0);
    chk("rd_cnt_cleared", rdata, 32'h0);
    cyc(1, 4'h0, BASE + 32'h14, 32'h0, 0);
    chk("wr_cnt_cleared", rdata, 32'h0);
    cyc(1, 4'h0, 32'h300, 32'h0, 0);
    chk("reset_wr_discarded", rdata, saved);

    // Randomized traffic against the model
    verbose = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 2) == 0)
        ra = BASE | 32'($urandom_range(0, 9) * 4) | 32'($urandom_range(0, 3));
      else
        ra = $urandom;
      cyc(($urandom_range(0, 4) != 0), rw, ra, $urandom, ($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: RAM depth is 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter MMIO_BASE, default 32'hBFAF_0000: base of the MMIO register window; only bits [31:16] are compared.
REQ-003 Parameter ID_VALUE, default 32'h4C41_3332: constant returned by the ID register.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  access request, one access per cycle when high.
REQ-007 we  input  4  byte write enables; we[i] covers wdata[8i+7:8i]; all-zero means read.
REQ-008 addr  input  32  byte address; addr[1:0] ignored.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  registered read data.
REQ-011 led  output  16  LED register value.
REQ-012 timer  output  32  free-running timer value.

Function
REQ-013 Decode: MMIO access if addr[31:16]==MMIO_BASE[31:16]; otherwise RAM access.
REQ-014 RAM word index = addr[DEPTH_LOG2+1:2]; higher address bits ignored, so indexing wraps modulo 2^DEPTH_LOG2.
REQ-015 Fixed latency: an access issued in cycle N (en=1) drives rdata at cycle N+1; there is no stall or ready signal, and back-to-back accesses are supported every cycle.
REQ-016 en=0 -> rdata holds its previous value and no state changes, except timer increment.
REQ-017 Write (en=1, we!=0): only lanes with we[i]=1 are updated; other lanes are preserved.
REQ-018 Read-first: an access with we!=0 returns the pre-write contents on rdata at N+1.
REQ-019 A read at N+1 of a word written at N returns the new data.
REQ-020 MMIO map (offset = addr[15:0]):
- 0x00 LED: RW; bits [15:0] only; reads return zero-extended.
- 0x04 TIMER: RW, byte-enabled.
- 0x08 SCRATCH: RW 32-bit, byte-enabled.
- 0x0C ID: RO, returns ID_VALUE.
- 0x10 RD_CNT: RO.
- 0x14 WR_CNT: RO.
REQ-021 Unmapped MMIO offsets read 0; writes to them and to RO registers are ignored.
REQ-022 TIMER increments by 1 each cycle, wrapping from FFFF_FFFF to 0.
REQ-023 TIMER write takes priority over increment: after a write in cycle N, timer equals the merged written value at N+1 and increments from N+2.
REQ-024 A TIMER read returns the value held in cycle N.
REQ-025 RD_CNT increments on each RAM read and WR_CNT on each RAM write; both saturate at FFFF_FFFF; MMIO accesses are not counted.
REQ-026 Each RAM access updates exactly one counter; the counters are never cleared except by reset.
REQ-027 led and timer outputs reflect register state directly, with no added latency.

Reset
REQ-028 reset=1 at a clock edge -> rdata=0, led=0, timer=0, SCRATCH=0, RD_CNT=0, WR_CNT=0.
REQ-029 RAM contents are not reset.
REQ-030 An access presented while reset=1 is discarded: no write occurs, no counter changes, and rdata=0 in the following cycle.
REQ-031 Reset asserted mid-stream does not corrupt RAM words other than through accesses completed before the reset.
REQ-032 On the first cycle after reset deasserts, timer=0, then increments.

Verification
REQ-033 Byte-lane write: write 32'h1122_3344 with we=4'hF to 0x100, then 32'hAAxx_xxxx with we=4'h8 -> a read of 0x100 returns 32'hAA22_3344.
REQ-034 Read-first and back-to-back: 0x200 holds 5; write 9 to 0x200 at N, then read 0x200 at N+1 -> rdata=5 at N+1 and rdata=9 at N+2.
REQ-035 Wrap: with DEPTH_LOG2=10, write 32'hCAFE to 0x1000_0000, then read 0x0000_0000 -> returns 32'hCAFE.
REQ-036 Timer: write 32'hFFFF_FFFE to MMIO_BASE+4 -> timer=FFFF_FFFE, then FFFF_FFFF, then 0 on successive cycles.
REQ-037 MMIO: write 32'h0001_ABCD to MMIO_BASE+0 -> led=16'hABCD and a read returns 32'h0000_ABCD; a read of MMIO_BASE+0xC returns ID_VALUE; a write to MMIO_BASE+0x20 leaves all state unchanged.
REQ-038 Counters and reset: perform 3 RAM reads and 2 RAM writes -> RD_CNT=3 and WR_CNT=2; assert reset during a write to 0x300 -> the word is unchanged and both counters read 0.
